// File: rtl/fp_ret_collector.sv
// Completion collector for the three-FPU half cluster: packs up to six unit
// completions per cycle into a circular queue and presents the two oldest entries.
module fp_ret_collector #(
  parameter int DEPTH    = 16,
  parameter int STALL_TH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [13:0]   u1_ret,
  input  logic [13:0]   u2_ret,
  input  logic [13:0]   u3_ret,
  input  logic [13:0]   u4_ret,
  input  logic [13:0]   u5_ret,
  input  logic [13:0]   u6_ret,
  input  logic          u1_ret_en,
  input  logic          u2_ret_en,
  input  logic          u3_ret_en,
  input  logic          u4_ret_en,
  input  logic          u5_ret_en,
  input  logic          u6_ret_en,
  output logic [16:0]   out0_data,
  output logic          out0_vld,
  output logic [16:0]   out1_data,
  output logic          out1_vld,
  input  logic [1:0]    out_take,
  output logic          issue_stall,
  output logic          overflow,
  output logic [CW-1:0] count
);

  logic [16:0]   q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [13:0]   ret_vec [6];
  logic [5:0]    ret_en;

  logic [CW-1:0] take_c;
  logic [CW-1:0] count_mid;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] accepted;
  logic          drop;
  logic [5:0]    wr_en;
  logic [PW-1:0] wr_idx [6];

  assign ret_vec[0] = u1_ret;
  assign ret_vec[1] = u2_ret;
  assign ret_vec[2] = u3_ret;
  assign ret_vec[3] = u4_ret;
  assign ret_vec[4] = u5_ret;
  assign ret_vec[5] = u6_ret;
  assign ret_en     = {u6_ret_en, u5_ret_en, u4_ret_en, u3_ret_en, u2_ret_en, u1_ret_en};

  // Pop first, then pack arrivals into whatever room the pop left.
  always_comb begin
    take_c     = (CW'(out_take) > count) ? count : CW'(out_take);
    count_mid  = count - take_c;
    free_slots = CW'(DEPTH) - count_mid;
    accepted   = '0;
    drop       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en[i]  = 1'b0;
      wr_idx[i] = wr_ptr + accepted[PW-1:0];
      if (ret_en[i]) begin
        if (accepted < free_slots) begin
          wr_en[i] = 1'b1;
          accepted = accepted + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Queue storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      for (int i = 0; i < 6; i++) begin
        if (wr_en[i]) q[wr_idx[i]] <= {3'(i), ret_vec[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      rd_ptr   <= rd_ptr + take_c[PW-1:0];
      wr_ptr   <= wr_ptr + accepted[PW-1:0];
      count    <= count_mid + accepted;
      overflow <= overflow | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      assert (CW'(out_take) <= count)
        else $error("fp_ret_collector: out_take %0d exceeds occupancy %0d", out_take, count);
    end
  end

  // Output view depends on registered state only; stale entries read as zero.
  assign out0_vld    = (count >= CW'(1));
  assign out1_vld    = (count >= CW'(2));
  assign out0_data   = out0_vld ? q[rd_ptr] : '0;
  assign out1_data   = out1_vld ? q[rd_ptr + PW'(1)] : '0;
  assign issue_stall = (CW'(DEPTH) - count) < CW'(STALL_TH);

endmodule

// File: tb/tb_fp_ret_collector.sv
// Directed bench for fp_ret_collector with a small FIFO reference for queue contents.
module tb_fp_ret_collector;

  localparam int DEPTH    = 16;
  localparam int STALL_TH = 8;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [13:0]   ret [6];
  logic [5:0]    en;
  logic [16:0]   out0_data;
  logic          out0_vld;
  logic [16:0]   out1_data;
  logic          out1_vld;
  logic [1:0]    out_take;
  logic          issue_stall;
  logic          overflow;
  logic [CW-1:0] count;

  int compared   = 0;
  int mismatched = 0;

  logic [16:0] exp_q [$];
  logic        exp_ovf;
  logic [13:0] seq;

  always #5 clk = ~clk;

  fp_ret_collector #(.DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .u1_ret(ret[0]), .u2_ret(ret[1]), .u3_ret(ret[2]),
    .u4_ret(ret[3]), .u5_ret(ret[4]), .u6_ret(ret[5]),
    .u1_ret_en(en[0]), .u2_ret_en(en[1]), .u3_ret_en(en[2]),
    .u4_ret_en(en[3]), .u5_ret_en(en[4]), .u6_ret_en(en[5]),
    .out0_data(out0_data), .out0_vld(out0_vld),
    .out1_data(out1_data), .out1_vld(out1_vld),
    .out_take(out_take), .issue_stall(issue_stall),
    .overflow(overflow), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v)
      else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_view(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".out0_vld"}, 32'(out0_vld), 32'(sz >= 1));
    chk({tag, ".out1_vld"}, 32'(out1_vld), 32'(sz >= 2));
    if (sz >= 1) chk({tag, ".out0_data"}, 32'(out0_data), 32'(exp_q[0]));
    if (sz >= 2) chk({tag, ".out1_data"}, 32'(out1_data), 32'(exp_q[1]));
    chk({tag, ".issue_stall"}, 32'(issue_stall), 32'((DEPTH - sz) < STALL_TH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // One clock: check current view, drive mask/take/flush, advance the reference.
  task automatic run_cycle(input string tag, input logic [5:0] mask, input int take, input bit fl);
    check_view(tag);
    for (int i = 0; i < 6; i++) ret[i] = seq + 14'(i);
    en       = mask;
    out_take = 2'(take);
    flush    = fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      for (int k = 0; k < take; k++) void'(exp_q.pop_front());
      for (int i = 0; i < 6; i++) begin
        if (mask[i]) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({3'(i), ret[i]});
          else exp_ovf = 1'b1;
        end
      end
    end
    step();
    seq      = seq + 14'd6;
    en       = '0;
    out_take = '0;
    flush    = 1'b0;
  endtask

  logic [5:0] wrap_masks [12];

  initial begin
    wrap_masks = '{6'h3F, 6'h3F, 6'h00, 6'h2A, 6'h3F, 6'h00,
                   6'h20, 6'h3F, 6'h00, 6'h1F, 6'h21, 6'h00};
    seq      = 14'h0100;
    exp_ovf  = 1'b0;
    rst      = 1'b0;
    flush    = 1'b0;
    out_take = '0;
    en       = 6'h3F;
    for (int i = 0; i < 6; i++) ret[i] = 14'h0100 + 14'(i);

    // Reset held with all completions active
    step();
    step();
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.out0_vld", 32'(out0_vld), 32'd0);
    chk("rst.out1_vld", 32'(out1_vld), 32'd0);
    chk("rst.out0_data", 32'(out0_data), 32'd0);
    chk("rst.out1_data", 32'(out1_data), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.issue_stall", 32'(issue_stall), 32'd0);

    rst = 1'b1;
    chk("release.count", 32'(count), 32'd0);
    run_cycle("release", 6'h3F, 0, 1'b0);
    chk("release_next.count", 32'(count), 32'd6);
    chk("release_next.out0_data", 32'(out0_data), 32'h00100);
    chk("release_next.out1_data", 32'(out1_data), 32'h04101);
    run_cycle("drain_a", 6'h00, 2, 1'b0);
    run_cycle("drain_b", 6'h00, 2, 1'b0);
    run_cycle("drain_c", 6'h00, 2, 1'b0);

    // Packing order: u2 and u5 only
    check_view("pack_pre");
    ret[1] = 14'h00AA;
    ret[4] = 14'h0155;
    en     = 6'b010010;
    exp_q.push_back(17'h040AA);
    exp_q.push_back(17'h10155);
    step();
    en = '0;
    chk("pack.out0_data", 32'(out0_data), 32'h040AA);
    chk("pack.out1_data", 32'(out1_data), 32'h10155);
    chk("pack.out0_vld", 32'(out0_vld), 32'd1);
    chk("pack.out1_vld", 32'(out1_vld), 32'd1);
    chk("pack.count", 32'(count), 32'd2);
    run_cycle("pack_drain", 6'h00, 2, 1'b0);

    // Mixed-rate traffic wrapping the pointers several times
    for (int c = 0; c < 12; c++) begin
      run_cycle($sformatf("wrap%0d", c), wrap_masks[c], (exp_q.size() >= 2) ? 2 : exp_q.size(), 1'b0);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      run_cycle($sformatf("wrap_drain%0d", c), 6'h00, (exp_q.size() >= 2) ? 2 : 1, 1'b0);
    end
    chk("wrap_done.count", 32'(count), 32'd0);

    // Stall threshold around count 8/9
    run_cycle("stall_f0", 6'h3F, 0, 1'b0);
    run_cycle("stall_f1", 6'h03, 0, 1'b0);
    chk("stall8.count", 32'(count), 32'd8);
    chk("stall8.issue_stall", 32'(issue_stall), 32'd0);
    run_cycle("stall_push", 6'h01, 0, 1'b0);
    chk("stall9.count", 32'(count), 32'd9);
    chk("stall9.issue_stall", 32'(issue_stall), 32'd1);
    run_cycle("stall_pop", 6'h00, 1, 1'b0);
    chk("stall_back.issue_stall", 32'(issue_stall), 32'd0);

    // Flush colliding with pop and arrivals
    run_cycle("fl_p0", 6'h00, 2, 1'b0);
    run_cycle("fl_p1", 6'h00, 1, 1'b0);
    chk("fl_pre.count", 32'(count), 32'd5);
    run_cycle("flush", 6'h07, 2, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out0_vld", 32'(out0_vld), 32'd0);
    chk("flush.overflow", 32'(overflow), 32'd0);

    // Overflow: fill to 14, then six arrivals
    run_cycle("ov_f0", 6'h3F, 0, 1'b0);
    run_cycle("ov_f1", 6'h3F, 0, 1'b0);
    run_cycle("ov_f2", 6'h03, 0, 1'b0);
    chk("ov14.count", 32'(count), 32'd14);
    chk("ov14.overflow", 32'(overflow), 32'd0);
    run_cycle("ov_hit", 6'h3F, 0, 1'b0);
    chk("ov16.count", 32'(count), 32'd16);
    chk("ov16.overflow", 32'(overflow), 32'd1);
    run_cycle("ov_swap", 6'h03, 2, 1'b0);
    chk("ov_swap.count", 32'(count), 32'd16);
    chk("ov_swap.overflow", 32'(overflow), 32'd1);
    run_cycle("ov_full", 6'h3F, 0, 1'b0);
    chk("ov_full.count", 32'(count), 32'd16);
    for (int c = 0; c < 6; c++) run_cycle($sformatf("ov_drain%0d", c), 6'h00, 2, 1'b0);
    run_cycle("ov_flush", 6'h3F, 0, 1'b1);
    chk("ov_flush.count", 32'(count), 32'd0);
    chk("ov_flush.overflow", 32'(overflow), 32'd1);

    // Only reset clears the sticky overflow
    rst = 1'b0;
    step();
    chk("rst2.overflow", 32'(overflow), 32'd0);
    chk("rst2.count", 32'(count), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_view("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
